fetch_unit: RTL

- Parametrised instruction-fetch stage for the pipelined RINSC core; the next generation of the single-register IF stage.
- Decouples instruction memory from decode through a DEPTH-entry prefetch queue, which allows one fetch per cycle to continue while decode is stalled.
- Redirects from branch/jump resolution flush the queue and restart fetch from the new address.
- Hands {instruction, PC+ISTEP} pairs to the IF/ID consumer with a valid/ready handshake.

---
 rtl/fetch_unit.sv | 105 ++++++++++
 1 files changed

// File: rtl/fetch_unit.sv
// fetch_unit: IF stage with a DEPTH-entry show-ahead prefetch queue, redirect flush, optional perf counters (FETCH_PERF_CNT_EN)
module fetch_unit #(
   parameter int              PC_W     = 7,
   parameter int              INSTR_W  = 32,
   parameter int              DEPTH    = 4,
   parameter int              ISTEP    = 4,
   parameter logic [PC_W-1:0] PC_RESET = '0
) (
   input  logic               clk,
   input  logic               reset,
   output logic               imem_req,
   output logic [PC_W-1:0]    imem_addr,
   input  logic [INSTR_W-1:0] imem_rdata,
   input  logic               redirect_valid,
   input  logic [PC_W-1:0]    redirect_addr,
   input  logic               id_ready,
   output logic               if_valid,
   output logic [INSTR_W-1:0] if_instr,
   output logic [PC_W-1:0]    if_pc_inc,
   output logic [31:0]        perf_stall_cnt,
   output logic [31:0]        perf_flush_cnt,
   output logic [31:0]        perf_empty_cnt
);
   localparam int PW = $clog2(DEPTH);
   localparam int CW = PW + 1;

   logic [PC_W-1:0]    r_pc, r_tag;
   logic               r_inflight;
   logic [INSTR_W-1:0] r_q_instr [DEPTH];
   logic [PC_W-1:0]    r_q_pc [DEPTH];
   logic [PW-1:0]      r_wp, r_rp;
   logic [CW-1:0]      r_count;
   logic               w_push, w_pop;

   // request only when a queue slot is reserved for it; head shown combinationally
   always_comb begin
      imem_req  = !reset && !redirect_valid && ((r_count + CW'(r_inflight)) < CW'(DEPTH));
      imem_addr = r_pc;
      if_valid  = !reset && !redirect_valid && (r_count != '0);
      w_pop     = if_valid && id_ready;
      w_push    = r_inflight && !redirect_valid;
      if_instr  = if_valid ? r_q_instr[r_rp] : '0;
      if_pc_inc = if_valid ? r_q_pc[r_rp] : '0;
   end

   // pc, in-flight tag and queue pointers; reset beats redirect beats normal flow
   always_ff @(posedge clk) begin
      if (reset) begin
         r_pc       <= PC_RESET;
         r_tag      <= '0;
         r_inflight <= 1'b0;
         r_wp       <= '0;
         r_rp       <= '0;
         r_count    <= '0;
      end else if (redirect_valid) begin
         r_pc       <= redirect_addr;
         r_inflight <= 1'b0;
         r_wp       <= '0;
         r_rp       <= '0;
         r_count    <= '0;
      end else begin
         r_inflight <= imem_req;
         if (imem_req) begin
            r_pc  <= r_pc + PC_W'(ISTEP);
            r_tag <= r_pc + PC_W'(ISTEP);
         end
         if (w_push) r_wp <= r_wp + PW'(1);
         if (w_pop) r_rp <= r_rp + PW'(1);
         r_count <= r_count + CW'(w_push) - CW'(w_pop);
      end
   end

   // queue storage; the response to an unsquashed request lands at the tail
   always_ff @(posedge clk) begin
      if (!reset && w_push) begin
         r_q_instr[r_wp] <= imem_rdata;
         r_q_pc[r_wp]    <= r_tag;
      end
   end

`ifdef FETCH_PERF_CNT_EN
   logic [31:0] r_stall, r_flush, r_empty;

   // saturating event counters
   always_ff @(posedge clk) begin
      if (reset) begin
         r_stall <= '0;
         r_flush <= '0;
         r_empty <= '0;
      end else begin
         if (if_valid && !id_ready && r_stall != '1) r_stall <= r_stall + 32'd1;
         if (redirect_valid && r_flush != '1) r_flush <= r_flush + 32'd1;
         if (!if_valid && r_empty != '1) r_empty <= r_empty + 32'd1;
      end
   end

   assign perf_stall_cnt = r_stall;
   assign perf_flush_cnt = r_flush;
   assign perf_empty_cnt = r_empty;
`else
   assign perf_stall_cnt = '0;
   assign perf_flush_cnt = '0;
   assign perf_empty_cnt = '0;
`endif
endmodule
